offset_check_pipe: RTL
======================

# offset_check_pipe

Parametrised two-stage streaming processor. Each accepted word gets a constant offset added. The result is range-checked against a threshold and flagged per beat, and error events are accumulated in a sticky flag and a saturating counter. Compared with the fixed 32-bit add/check stage, it adds valid/ready flow control, selectable wrap or saturate arithmetic, carry-aware error detection and error statistics. It sits between the input capture logic and downstream consumers of processed data.

## Interface
- WIDTH, 32, data width in bits (≥ 2)
- OFFSET, 32'hA5A5A5A5, constant added to every word (WIDTH bits)
- THRESHOLD, 32'hFFFFFF00, result strictly greater than this is an error
- SATURATE, 0, 0 = wrap on overflow, 1 = clamp result to all-ones
- ERR_CNT_W, 8, width of error event counter

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  input word present
- in_ready  out  1  block can accept this cycle
- in_data  in  WIDTH  input word
- out_valid  out  1  output word present
- out_ready  in  1  consumer accepts this cycle
- out_data  out  WIDTH  processed word
- out_err  out  1  error status of the current output word; qualified by out_valid
- err_sticky  out  1  set by any error transfer; held until cleared
- err_count  out  ERR_CNT_W  number of error transfers, saturating
- clear_err  in  1  synchronous clear of err_sticky and err_count

## Operation
- Stage 1 registers sum = in_data + OFFSET at WIDTH+1 bits (carry = bit WIDTH), plus s1_valid.
- Stage 2 registers the following from stage 1, plus s2_valid:
  - out_data = (SATURATE && carry) ? all-ones : sum[WIDTH-1:0]
  - out_err = carry || (sum[WIDTH-1:0] > THRESHOLD), unsigned compare on the unclamped low bits
- An error is flagged on carry in both modes.
- Flow control:
  - adv2 = !s2_valid || out_ready
  - adv1 = !s1_valid || adv2
  - in_ready = adv1
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready. out_valid = s2_valid.
- Stages load only on their advance signal. A stalled stage holds its data and valid unchanged. No bubbles are inserted when both stages are full and out_ready is high; throughput is 1 word per cycle.
- Error event = output transfer with out_err = 1. A stalled erroneous word is counted once, at transfer.
- err_count increments per event and saturates at 2^ERR_CNT_W−1. err_sticky is set on any event.
- clear_err in the same cycle as an event: the clear applies first and the event is still recorded, giving err_count = 1 and err_sticky = 1.
- Data order is strictly preserved. No words are dropped or duplicated.

## Timing
- Reset values (asynchronous assert):
  - s1_valid, s2_valid, out_valid = 0
  - out_data = 0, out_err = 0, err_sticky = 0, err_count = 0
  - in_ready = 1 once reset deasserts
- Latency: a word accepted at edge N is presented on out_data with out_valid = 1 after edge N+1. If out_ready is high, it transfers at edge N+2.
- in_ready is combinational from out_ready and the valid registers. out_data, out_err and out_valid are registered.
- Backpressure: with out_ready held low, at most 2 words are absorbed. in_ready falls in the cycle after the second word is accepted.
- Reset mid-stream: all in-flight words are discarded. No output transfer occurs until new input arrives.
- out_data and out_err must stay stable while out_valid = 1 and out_ready = 0.

## Test plan
- Defaults, in_data 0x00000001 with out_ready = 1 → out_data 0xA5A5A5A6, out_err 0, two cycles later; err_count stays 0.
- in_data 0x5A5A5A5A → out_data 0xFFFFFFFF, out_err 1 (above threshold, no carry); err_count 1, err_sticky 1.
- in_data 0x5A5A5A5B → wrap mode: 0x00000000, out_err 1 (carry). SATURATE = 1: 0xFFFFFFFF, out_err 1.
- Backpressure:
  - Stimulus: stream 0x10, 0x11, 0x12 with out_ready = 0 for 5 cycles, then out_ready = 1.
  - Response: in_ready low after 2 accepts. Outputs arrive in order as 0xA5A5A5B5, 0xA5A5A5B6, 0xA5A5A5B7, with no loss or duplication.
  - A stalled error word is counted once.
- ERR_CNT_W = 2, 5 error transfers → err_count 3. Then clear_err coincident with a 6th error → err_count 1, err_sticky 1.
- Assert reset with 2 words in flight and err_count 2 → outputs return to reset values immediately. No stale word appears after release.

Source files
------------

// File: rtl/offset_check_pipe.sv
// Two-stage streaming offset adder with a threshold check per beat and error statistics.
// Valid/ready flow control throughout; each stage holds its contents while stalled.
module offset_check_pipe #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] OFFSET    = 32'hA5A5A5A5,
    parameter logic [WIDTH-1:0] THRESHOLD = 32'hFFFFFF00,
    parameter bit               SATURATE  = 1'b0,
    parameter int unsigned      ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_err,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic                 clear_err
);

    localparam logic [ERR_CNT_W-1:0] CntMax = '1;

    logic                 adv1, adv2;
    logic [WIDTH:0]       sum_d;
    logic [WIDTH:0]       s1_sum_q;
    logic                 s1_valid_q;
    logic                 s1_carry;
    logic [WIDTH-1:0]     s1_low;
    logic [WIDTH-1:0]     s2_data_d, s2_data_q;
    logic                 s2_err_d, s2_err_q;
    logic                 s2_valid_q;
    logic                 err_event;
    logic                 err_sticky_d, err_sticky_q;
    logic [ERR_CNT_W-1:0] count_base;
    logic [ERR_CNT_W-1:0] err_count_d, err_count_q;

    assign adv2     = !s2_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1;

    assign sum_d    = {1'b0, in_data} + {1'b0, OFFSET};
    assign s1_carry = s1_sum_q[WIDTH];
    assign s1_low   = s1_sum_q[WIDTH-1:0];

    // The threshold compare uses the unclamped low bits; a carry is an error in both modes.
    always_comb begin
        s2_data_d = (SATURATE && s1_carry) ? '1 : s1_low;
        s2_err_d  = s1_carry || (s1_low > THRESHOLD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
        end else if (adv1) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sum_q <= sum_d;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_err_q   <= 1'b0;
        end else if (adv2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= s2_data_d;
                s2_err_q  <= s2_err_d;
            end
        end
    end

    assign err_event = s2_valid_q && out_ready && s2_err_q;

    // A clear coincident with an event is applied first, so the event still counts.
    always_comb begin
        count_base   = clear_err ? '0 : err_count_q;
        err_count_d  = count_base;
        if (err_event && (count_base != CntMax)) begin
            err_count_d = count_base + ERR_CNT_W'(1);
        end
        err_sticky_d = (err_sticky_q && !clear_err) || err_event;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count_q  <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            err_count_q  <= err_count_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_data   = s2_data_q;
    assign out_err    = s2_err_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;

endmodule
